// File: rtl/ff_mb_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : ff_mb_sync_rx
// Description : Destination-side endpoint for toggle-flag multibit crossings
//               from CHANNELS independent source domains. Each channel's
//               flag is synchronised and edge-detected. The source-held data
//               word is captured into a per-channel hold register. A toggle
//               ack is returned once the word has been pushed into a shared
//               FIFO. A round-robin arbiter picks one pending channel per
//               cycle.
// Ports       : i_clk, i_rst         destination clock, sync active-high reset
//               i_xfer_flag          per-channel async toggle from source
//               i_data               per-channel source-held data words
//               o_ack_flag           per-channel toggle ack to source
//               o_valid/o_data/o_chan FIFO head (data, channel) and valid
//               i_ready              consumer pops head on o_valid & i_ready
//               o_overflow           sticky per-channel protocol violation
// Revision    : 1.0 - initial release
// ============================================================================
module ff_mb_sync_rx #(
   parameter int DATA_W      = 16,
   parameter int CHANNELS    = 2,
   parameter int SYNC_STAGES = 2,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                                            i_clk,
   input  logic                                            i_rst,
   input  logic [CHANNELS-1:0]                             i_xfer_flag,
   input  logic [CHANNELS*DATA_W-1:0]                      i_data,
   output logic [CHANNELS-1:0]                             o_ack_flag,
   output logic                                            o_valid,
   output logic [DATA_W-1:0]                               o_data,
   output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] o_chan,
   input  logic                                            i_ready,
   output logic [CHANNELS-1:0]                             o_overflow
);

   localparam int c_CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int c_ADDR_W  = $clog2(FIFO_DEPTH);
   localparam int c_ENTRY_W = c_CHAN_W + DATA_W;
   localparam logic [c_ADDR_W:0]   c_FULL     = FIFO_DEPTH[c_ADDR_W:0];
   localparam logic [c_CHAN_W-1:0] c_LAST_CH  = c_CHAN_W'(CHANNELS - 1);

   // Per-channel crossing state
   logic [SYNC_STAGES-1:0] r_sync [CHANNELS];
   logic [CHANNELS-1:0]    r_edge;
   logic [CHANNELS-1:0]    r_pend;
   logic [CHANNELS-1:0]    r_ack;
   logic [CHANNELS-1:0]    r_ovf;
   logic [DATA_W-1:0]      r_hold [CHANNELS];
   logic [CHANNELS-1:0]    w_tog;
   logic [CHANNELS-1:0]    w_gnt_vec;

   // Arbiter
   logic [c_CHAN_W-1:0]    r_rr;
   logic [c_CHAN_W-1:0]    w_gnt_idx;
   logic [c_CHAN_W-1:0]    w_rr_nxt;
   logic                   w_gnt_any;

   // Shared FIFO
   logic [c_ENTRY_W-1:0]   r_mem [FIFO_DEPTH];
   logic [c_ADDR_W-1:0]    r_wr;
   logic [c_ADDR_W-1:0]    r_rd;
   logic [c_ADDR_W:0]      r_cnt;
   logic                   w_push;
   logic                   w_pop;
   logic                   w_push_ok;

   // ------------------------------------------------------------------------
   // Flag edge detection and grant decode
   // ------------------------------------------------------------------------
   always_comb begin
      w_tog     = '0;
      w_gnt_vec = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         w_tog[c]     = r_sync[c][SYNC_STAGES-1] ^ r_edge[c];
         w_gnt_vec[c] = w_push && (w_gnt_idx == c_CHAN_W'(c));
      end
   end

   // ------------------------------------------------------------------------
   // Synchronisers, capture, pending, ack and overflow
   // A grant always clears a pending word before a new toggle can set it,
   // because a grant requires pending to already be set.
   // ------------------------------------------------------------------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sync[c] <= '0;
            r_hold[c] <= '0;
         end
         r_edge <= '0;
         r_pend <= '0;
         r_ack  <= '0;
         r_ovf  <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], i_xfer_flag[c]};
            r_edge[c] <= r_sync[c][SYNC_STAGES-1];
            if (w_gnt_vec[c]) begin
               r_pend[c] <= 1'b0;
               r_ack[c]  <= ~r_ack[c];
            end
            if (w_tog[c]) begin
               if (r_pend[c]) begin
                  // Source toggled again before its previous word was acked;
                  // the new word is dropped and the held word kept.
                  r_ovf[c] <= 1'b1;
               end else begin
                  r_hold[c] <= i_data[c*DATA_W +: DATA_W];
                  r_pend[c] <= 1'b1;
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Round-robin arbiter: first pending channel at or after r_rr, wrapping.
   // Scanning from the farthest offset down lets the nearest one win.
   // ------------------------------------------------------------------------
   always_comb begin
      w_gnt_any = 1'b0;
      w_gnt_idx = '0;
      for (int i = CHANNELS - 1; i >= 0; i--) begin
         if (r_pend[(int'(r_rr) + i) % CHANNELS]) begin
            w_gnt_any = 1'b1;
            w_gnt_idx = c_CHAN_W'((int'(r_rr) + i) % CHANNELS);
         end
      end
   end

   assign w_rr_nxt = (w_gnt_idx == c_LAST_CH) ? '0 : w_gnt_idx + 1'b1;

   // ------------------------------------------------------------------------
   // Shared FIFO; a full FIFO still accepts a push when the head pops in the
   // same cycle.
   // ------------------------------------------------------------------------
   assign o_valid   = (r_cnt != '0);
   assign w_pop     = o_valid & i_ready;
   assign w_push_ok = (r_cnt != c_FULL) | w_pop;
   assign w_push    = w_gnt_any & w_push_ok;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
         r_rr  <= '0;
      end else begin
         if (w_push) begin
            r_wr <= r_wr + 1'b1;
            r_rr <= w_rr_nxt;
         end
         if (w_pop) begin
            r_rd <= r_rd + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

   // Storage carries no reset; entries are only visible through r_cnt.
   always_ff @(posedge i_clk) begin
      if (w_push) begin
         r_mem[r_wr] <= {w_gnt_idx, r_hold[w_gnt_idx]};
      end
   end

   assign o_data     = o_valid ? r_mem[r_rd][DATA_W-1:0]         : '0;
   assign o_chan     = o_valid ? r_mem[r_rd][c_ENTRY_W-1:DATA_W] : '0;
   assign o_ack_flag = r_ack;
   assign o_overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_ff_mb_sync_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ff_mb_sync_rx
// Description : Directed self-checking bench for ff_mb_sync_rx with default
//               parameters (16-bit data, 2 channels, 2 sync stages, 4-deep
//               FIFO). Inputs change 1 time unit after a rising edge and
//               outputs are checked at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ff_mb_sync_rx;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  xfer;
   logic [31:0] din;
   logic [1:0]  ack;
   logic        valid;
   logic [15:0] dout;
   logic        chan;
   logic        ready;
   logic [1:0]  ovf;

   logic [1:0]  exp_ack;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   ff_mb_sync_rx #(
      .DATA_W      (16),
      .CHANNELS    (2),
      .SYNC_STAGES (2),
      .FIFO_DEPTH  (4)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_xfer_flag (xfer),
      .i_data      (din),
      .o_ack_flag  (ack),
      .o_valid     (valid),
      .o_data      (dout),
      .o_chan      (chan),
      .i_ready     (ready),
      .o_overflow  (ovf)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic v, input logic [15:0] d, input logic c);
      chk({tag, "_valid"}, valid, v);
      chk({tag, "_data"},  dout,  d);
      chk({tag, "_chan"},  chan,  c);
   endtask

   task automatic send(input int ch, input logic [15:0] d);
      din[ch*16 +: 16] = d;
      xfer[ch]         = ~xfer[ch];
   endtask

   // One word on one channel with an idle FIFO and i_ready=1.
   task automatic single(input int ch, input logic [15:0] d, input string tag);
      send(ch, d);
      repeat (3) tick;
      chk({tag, "_pre_valid"}, valid, 1'b0);
      chk({tag, "_pre_ack"},   ack,   exp_ack);
      tick;
      exp_ack[ch] = ~exp_ack[ch];
      chk_head(tag, 1'b1, d, ch[0]);
      chk({tag, "_ack"}, ack, exp_ack);
      tick;
      chk_head({tag, "_drained"}, 1'b0, 16'h0000, 1'b0);
      chk({tag, "_ovf"}, ovf, 2'b00);
   endtask

   // Both channels toggled together; 'first' is the channel the round-robin
   // pointer should grant first.
   task automatic pair(input logic [15:0] a0, input logic [15:0] a1,
                       input logic first, input string tag);
      send(0, a0);
      send(1, a1);
      repeat (3) tick;
      chk({tag, "_pre_valid"}, valid, 1'b0);
      tick;
      exp_ack[first] = ~exp_ack[first];
      chk_head({tag, "_w1"}, 1'b1, first ? a1 : a0, first);
      chk({tag, "_ack1"}, ack, exp_ack);
      tick;
      exp_ack[~first] = ~exp_ack[~first];
      chk_head({tag, "_w2"}, 1'b1, first ? a0 : a1, ~first);
      chk({tag, "_ack2"}, ack, exp_ack);
      tick;
      chk({tag, "_drained"}, valid, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      rst     = 1'b1;
      xfer    = 2'b00;
      din     = '0;
      ready   = 1'b1;
      exp_ack = 2'b00;

      // Reset state
      repeat (2) tick;
      chk_head("rst_in", 1'b0, 16'h0000, 1'b0);
      rst = 1'b0;
      tick;
      chk_head("rst_out", 1'b0, 16'h0000, 1'b0);
      chk("rst_ack", ack, 2'b00);
      chk("rst_ovf", ovf, 2'b00);

      // Same-cycle toggles from a fresh pointer: ch0 then ch1; pointer wraps
      // to 0 so the repeat again starts with ch0.
      pair(16'h1111, 16'h2222, 1'b0, "t2a");
      pair(16'h1212, 16'h2121, 1'b0, "t2b");

      // Single ch0 word; leaves pointer at 1
      single(0, 16'hA5A5, "t1");

      // Pointer now favours ch1
      pair(16'h3C3C, 16'hC3C3, 1'b1, "t2c");

      // Back-pressure: four words fill the FIFO, fifth waits un-acked
      ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(0, 16'hB001 + 16'(i));
         repeat (4) tick;
         exp_ack[0] = ~exp_ack[0];
         chk("t3_ack_fill", ack, exp_ack);
      end
      chk_head("t3_full_head", 1'b1, 16'hB001, 1'b0);
      send(0, 16'hB005);
      repeat (8) tick;
      chk("t3_ack_withheld", ack, exp_ack);
      chk_head("t3_held_head", 1'b1, 16'hB001, 1'b0);

      // Pop from a full FIFO and grant the pending word in the same edge
      ready = 1'b1;
      tick;
      exp_ack[0] = ~exp_ack[0];
      chk("t6_ack_on_pop", ack, exp_ack);
      chk_head("t6_head2", 1'b1, 16'hB002, 1'b0);
      tick;
      chk_head("t3_head3", 1'b1, 16'hB003, 1'b0);
      tick;
      chk_head("t3_head4", 1'b1, 16'hB004, 1'b0);
      tick;
      chk_head("t3_head5", 1'b1, 16'hB005, 1'b0);
      tick;
      chk("t3_empty", valid, 1'b0);
      chk("t3_ovf", ovf, 2'b00);

      // Double toggle on ch1 before the ack: 0x3333 held, second word dropped
      din[31:16] = 16'h3333;
      xfer[1]    = ~xfer[1];
      tick;
      xfer[1]    = ~xfer[1];
      tick;
      tick;
      chk("t4_pre_valid", valid, 1'b0);
      din[31:16] = 16'h4444;
      tick;
      exp_ack[1] = ~exp_ack[1];
      chk_head("t4_word", 1'b1, 16'h3333, 1'b1);
      chk("t4_ack", ack, exp_ack);
      chk("t4_ovf", ovf, 2'b10);
      tick;
      chk("t4_drained", valid, 1'b0);
      repeat (6) tick;
      chk("t4_no_second", valid, 1'b0);
      chk("t4_ovf_sticky", ovf, 2'b10);
      chk("t4_ack_once", ack, exp_ack);

      // Reset with two words queued and ch0 pending
      ready = 1'b0;
      send(0, 16'hC001);
      repeat (4) tick;
      exp_ack[0] = ~exp_ack[0];
      chk("t5_ack_w1", ack, exp_ack);
      send(0, 16'hC002);
      repeat (4) tick;
      exp_ack[0] = ~exp_ack[0];
      chk("t5_ack_w2", ack, exp_ack);
      chk_head("t5_queued_head", 1'b1, 16'hC001, 1'b0);
      send(0, 16'hC003);
      repeat (3) tick;
      rst     = 1'b1;
      xfer    = 2'b00;
      din     = '0;
      exp_ack = 2'b00;
      tick;
      chk_head("t5_after_rst", 1'b0, 16'h0000, 1'b0);
      chk("t5_rst_ack", ack, 2'b00);
      chk("t5_rst_ovf", ovf, 2'b00);
      tick;
      rst = 1'b0;
      tick;
      ready = 1'b1;
      single(0, 16'h5A5A, "t5_post");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
